ascon_final: RTL and testbench
==============================

Name: ascon_final

Overview:
Finalization stage of the Ascon AEAD datapath. It accepts the 320-bit state after the last plaintext/ciphertext block and injects the key. It runs the 12-round permutation one round per cycle, injects the key again and produces the 128-bit tag. In decrypt mode it also compares the tag against the received tag. The block sits downstream of the initialization and data-processing stages and is the mirror operation of the initialization stage.

Parameters:
RATE_WORDS, 1, rate in 64-bit words (1 = Ascon-128, key into x1/x2; 2 = Ascon-128a, key into x2/x3)
ROUNDS, 12, permutation rounds (fixed 12; values other than 12 are illegal)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
valid_i  input  1  input request valid
ready_o  output  1  block can accept a request
state_i  input  [4:0][63:0]  state after data processing
key_i  input  128  key K; K[127:64] is the first key word
decrypt_i  input  1  1 = verify tag_i
tag_i  input  128  received tag (decrypt only)
valid_o  output  1  tag result valid
ready_i  input  1  consumer accepts result
tag_o  output  128  computed tag {x3^K[127:64], x4^K[63:0]}
tag_ok_o  output  1  1 = tag_o == tag_i (forced 1 when decrypt_i was 0)
busy_o  output  1  permutation in progress

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high. All flops reset on the rising clk_i edge with rst_i=1.
- Reset values: fsm=IDLE, round=0, state/tag/key/tag_i registers=0, valid_o=0, tag_o=0, tag_ok_o=0, busy_o=0. ready_o=1 in the first cycle after reset deassertion.
- FSM states: IDLE, PERM, DONE.
- IDLE: ready_o=1. On valid_i&&ready_o, capture key_i, tag_i, decrypt_i, and load state. For RATE_WORDS=1: x1^=K[127:64], x2^=K[63:0]. For RATE_WORDS=2: x2^=K[127:64], x3^=K[63:0]. Then round<=0 and move to PERM.
- PERM: busy_o=1, ready_o=0. Each edge applies round r. Round r uses round constant c_r={4'(15-r),4'(r)} (0xF0, 0xE1 … 0x4B) XORed into x2[7:0], followed by the S-box layer and the linear layer. round increments 4-bit. On the edge applying round 11: tag_o, tag_ok_o and valid_o are registered, and the FSM moves to DONE.
- Latency: valid_o rises 13 edges after the accepting edge (1 load + 12 rounds).
- DONE: valid_o=1. tag_o and tag_ok_o are held stable while ready_i=0. On ready_i=1, valid_o<=0, tag_o and tag_ok_o are held, and the FSM moves to IDLE. The next request can be accepted no earlier than the cycle after the handshake.
- valid_i is ignored outside IDLE; no queuing.
- tag_ok_o compares the full 128 bits in a single comparator. For encrypt it is always 1.
- Reset mid-operation (any state): next cycle is IDLE with reset values; any partial result is discarded, with no valid_o pulse.
- Round counter never exceeds 11. Entering PERM with round≠0 is impossible by construction; assert in simulation.

Decomposition:
- ascon_pkg: state typedef (logic [4:0][63:0]), fsm enum {IDLE,PERM,DONE}, ROUNDS=12, function round_const(round) returning 8 bits.
- Sub-module ascon_round: purely combinational single round (constant add, 5-bit S-box over 64 slices, linear layer with rotations x0:19/28, x1:61/39, x2:1/6, x3:10/17, x4:7/41). It has no register interface.

Test Plan:
- Ascon-128 KAT (K=N=000102…0F, empty AD/PT): drive state_i from the golden model's pre-final state, decrypt_i=0 -> tag_o=E355159F292911F794CB1432A0103A8A, tag_ok_o=1, valid_o 13 edges after accept.
- Same stimulus with decrypt_i=1, tag_i=E355159F…3A8A -> tag_ok_o=1; repeat with tag_i bit 0 flipped -> tag_ok_o=0, tag_o unchanged.
- Backpressure: hold ready_i=0 for 5 cycles in DONE while pulsing valid_i -> tag_o/valid_o stable, ready_o=0, no new capture; release -> valid_o=0 next cycle, ready_o=1.
- Reset at round 6: assert rst_i one cycle -> next cycle valid_o=0, busy_o=0, ready_o=1; a subsequent request yields the correct KAT tag.
- Back-to-back: two requests with valid_i held high and ready_i=1 -> second accept exactly one cycle after the first DONE handshake, both tags match the model.
- RATE_WORDS=2 build, Ascon-128a KAT with empty AD/PT -> tag_o matches the reference model, key injected into x2/x3.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared types and round constant for the Ascon finalization datapath
package ascon_pkg;
  typedef logic [4:0][63:0] state_t;
  typedef enum logic [1:0] {IDLE, PERM, DONE} fsm_e;
  localparam int ROUNDS = 12;
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'(15 - r), r};
  endfunction
endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon permutation round (constant, S-box, linear layer)
module ascon_round (
  input  logic [4:0][63:0] s_i,
  input  logic [7:0]       c_i,
  output logic [4:0][63:0] s_o
);
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  logic [63:0] b0, b1, b2, b3, b4, y0, y1, y2, y3, y4, z0, z1, z2, z3, z4;
  // constant add folded into the S-box input mixing
  assign b0 = s_i[0] ^ s_i[4];
  assign b1 = s_i[1];
  assign b2 = s_i[2] ^ {56'd0, c_i} ^ s_i[1];
  assign b3 = s_i[3];
  assign b4 = s_i[4] ^ s_i[3];
  // chi-like core of the bitsliced 5-bit S-box
  assign y0 = b0 ^ (~b1 & b2);
  assign y1 = b1 ^ (~b2 & b3);
  assign y2 = b2 ^ (~b3 & b4);
  assign y3 = b3 ^ (~b4 & b0);
  assign y4 = b4 ^ (~b0 & b1);
  // S-box output mixing
  assign z0 = y0 ^ y4;
  assign z1 = y1 ^ y0;
  assign z2 = ~y2;
  assign z3 = y3 ^ y2;
  assign z4 = y4;
  // per-word linear diffusion
  assign s_o[0] = z0 ^ ror(z0, 19) ^ ror(z0, 28);
  assign s_o[1] = z1 ^ ror(z1, 61) ^ ror(z1, 39);
  assign s_o[2] = z2 ^ ror(z2, 1) ^ ror(z2, 6);
  assign s_o[3] = z3 ^ ror(z3, 10) ^ ror(z3, 17);
  assign s_o[4] = z4 ^ ror(z4, 7) ^ ror(z4, 41);
endmodule

// File: rtl/ascon_final.sv
// ascon_final: Ascon finalization - key injection, 12-round permutation, tag generation and check
module ascon_final #(
  parameter int RATE_WORDS = 1,
  parameter int ROUNDS = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0][63:0] state_i,
  input  logic [127:0]     key_i,
  input  logic             decrypt_i,
  input  logic [127:0]     tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [127:0]     tag_o,
  output logic             tag_ok_o,
  output logic             busy_o
);
  import ascon_pkg::*;
  if (ROUNDS != ascon_pkg::ROUNDS) begin : g_bad_rounds
    $error("ascon_final: ROUNDS must be 12");
  end
  if (RATE_WORDS != 1 && RATE_WORDS != 2) begin : g_bad_rate
    $error("ascon_final: RATE_WORDS must be 1 or 2");
  end
  localparam logic [2:0] KW = 3'(RATE_WORDS);
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);
  fsm_e fsm_q, fsm_d;
  logic [3:0] round_q, round_d;
  state_t st_q, st_d, rnd, ld;
  logic [127:0] key_q, key_d, tagi_q, tagi_d, tag_q, tag_d, fin_tag;
  logic dec_q, dec_d, valid_q, valid_d, ok_q, ok_d;
  logic [7:0] rc;
  assign rc = round_const(round_q);
  ascon_round u_round (.s_i(st_q), .c_i(rc), .s_o(rnd));
  assign fin_tag = {rnd[3] ^ key_q[127:64], rnd[4] ^ key_q[63:0]};
  assign ready_o = fsm_q == IDLE;
  assign busy_o = fsm_q == PERM;
  assign valid_o = valid_q;
  assign tag_o = tag_q;
  assign tag_ok_o = ok_q;
  // key goes into the two words just past the rate
  always_comb begin
    ld = state_i;
    ld[KW] = state_i[KW] ^ key_i[127:64];
    ld[KW + 3'd1] = state_i[KW + 3'd1] ^ key_i[63:0];
  end
  // next state: load on accept, one round per cycle, tag on the last round, hold until taken
  always_comb begin
    fsm_d = fsm_q;
    round_d = round_q;
    st_d = st_q;
    key_d = key_q;
    tagi_d = tagi_q;
    dec_d = dec_q;
    valid_d = valid_q;
    tag_d = tag_q;
    ok_d = ok_q;
    case (fsm_q)
      IDLE: if (valid_i) begin
        st_d = ld;
        key_d = key_i;
        tagi_d = tag_i;
        dec_d = decrypt_i;
        round_d = '0;
        fsm_d = PERM;
      end
      PERM: begin
        st_d = rnd;
        round_d = round_q + 4'd1;
        if (round_q == LAST) begin
          tag_d = fin_tag;
          ok_d = !dec_q || fin_tag == tagi_q;
          valid_d = 1'b1;
          round_d = '0;
          fsm_d = DONE;
        end
      end
      DONE: if (ready_i) begin
        valid_d = 1'b0;
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end
  // registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      round_q <= '0;
      st_q <= '0;
      key_q <= '0;
      tagi_q <= '0;
      dec_q <= 1'b0;
      valid_q <= 1'b0;
      tag_q <= '0;
      ok_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      round_q <= round_d;
      st_q <= st_d;
      key_q <= key_d;
      tagi_q <= tagi_d;
      dec_q <= dec_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      ok_q <= ok_d;
    end
  end
  a_round_max: assert property (@(posedge clk_i) disable iff (rst_i) round_q <= LAST);
  a_perm_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    (fsm_q == IDLE && fsm_d == PERM) |=> round_q == 4'd0);
endmodule

// File: tb/tb_ascon_final.sv
// tb_ascon_final: table, random and sequence checks of ascon_final against an S-box-table Ascon model
module tb_ascon_final;
  typedef logic [4:0][63:0] st_t;
  typedef struct {
    st_t s;
    logic [127:0] k;
    logic d;
    logic [127:0] t;
    logic [127:0] e1;
    logic o1;
    logic [127:0] e2;
    logic o2;
  } vec_t;
  localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                       5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                       5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                       5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [127:0] KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KT = 128'hE355159F292911F794CB1432A0103A8A;
  logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, ready_i = 1'b0, dec = 1'b0;
  st_t state_i = '0;
  logic [127:0] key_i = '0, tag_i = '0;
  logic v1, r1, ok1, b1, v2, r2, ok2, b2;
  logic [127:0] t1, t2;
  int total = 0, bad = 0;
  vec_t tv[6];
  always #5 clk = ~clk;
  ascon_final #(.RATE_WORDS(1), .ROUNDS(12)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r1), .state_i(state_i),
    .key_i(key_i), .decrypt_i(dec), .tag_i(tag_i), .valid_o(v1), .ready_i(ready_i),
    .tag_o(t1), .tag_ok_o(ok1), .busy_o(b1));
  ascon_final #(.RATE_WORDS(2), .ROUNDS(12)) dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r2), .state_i(state_i),
    .key_i(key_i), .decrypt_i(dec), .tag_i(tag_i), .valid_o(v2), .ready_i(ready_i),
    .tag_o(t2), .tag_ok_o(ok2), .busy_o(b2));
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic st_t perm(input st_t s);
    logic [4:0] v;
    for (int r = 0; r < 12; r++) begin
      s[2] = s[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        for (int i = 0; i < 5; i++) s[i][b] = v[4-i];
      end
      s[0] = s[0] ^ ror(s[0], 19) ^ ror(s[0], 28);
      s[1] = s[1] ^ ror(s[1], 61) ^ ror(s[1], 39);
      s[2] = s[2] ^ ror(s[2], 1) ^ ror(s[2], 6);
      s[3] = s[3] ^ ror(s[3], 10) ^ ror(s[3], 17);
      s[4] = s[4] ^ ror(s[4], 7) ^ ror(s[4], 41);
    end
    return s;
  endfunction
  function automatic logic [127:0] fin(input st_t s, input logic [127:0] k, input int rw);
    s[rw] = s[rw] ^ k[127:64];
    s[rw+1] = s[rw+1] ^ k[63:0];
    s = perm(s);
    return {s[3] ^ k[127:64], s[4] ^ k[63:0]};
  endfunction
  function automatic st_t pre(input logic [63:0] iv, input logic [127:0] k, input logic [127:0] n);
    st_t s;
    s[0] = iv;
    s[1] = k[127:64];
    s[2] = k[63:0];
    s[3] = n[127:64];
    s[4] = n[63:0];
    s = perm(s);
    s[3] = s[3] ^ k[127:64];
    s[4] = s[4] ^ k[63:0] ^ 64'd1;
    s[0] = s[0] ^ 64'h8000000000000000;
    return s;
  endfunction
  function automatic vec_t mk(input st_t s, input logic [127:0] k, input logic d, input logic [127:0] t);
    vec_t v;
    v.s = s;
    v.k = k;
    v.d = d;
    v.t = t;
    v.e1 = fin(s, k, 1);
    v.o1 = !d || v.e1 == t;
    v.e2 = fin(s, k, 2);
    v.o2 = !d || v.e2 == t;
    return v;
  endfunction
  function automatic st_t rnd_st();
    st_t s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
    return s;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    while (!v1 && n < 40) begin
      tick();
      n++;
    end
    chk("valid_timeout", 128'(v1), 128'd1);
  endtask
  task automatic run(input st_t s, input logic [127:0] k, input logic d, input logic [127:0] t,
                     output logic [127:0] g1, output logic o1, output logic [127:0] g2, output logic o2);
    int n;
    @(negedge clk);
    state_i = s;
    key_i = k;
    dec = d;
    tag_i = t;
    valid_i = 1'b1;
    ready_i = 1'b0;
    n = 0;
    while (!r1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    tick();
    valid_i = 1'b0;
    n = 1;
    while (!v1 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'd13);
    g1 = t1;
    o1 = ok1;
    g2 = t2;
    o2 = ok2;
    @(negedge clk);
    ready_i = 1'b1;
    tick();
    chk("valid_drop", 128'(v1), 128'd0);
    ready_i = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    st_t s128, s128a, sa, sb;
    logic [127:0] g1, g2, hold;
    logic o1, o2;
    s128 = pre(64'h80400c0600000000, KEY, KEY);
    s128a = pre(64'h80800c0800000000, KEY, KEY);
    tv[0] = mk(s128, KEY, 1'b0, '0);
    tv[0].e1 = KT;
    tv[0].o1 = 1'b1;
    tv[1] = mk(s128, KEY, 1'b1, KT);
    tv[1].e1 = KT;
    tv[1].o1 = 1'b1;
    tv[2] = mk(s128, KEY, 1'b1, KT ^ 128'd1);
    tv[2].e1 = KT;
    tv[2].o1 = 1'b0;
    tv[3] = mk(s128a, KEY, 1'b0, '0);
    tv[4] = mk(s128a, KEY, 1'b1, fin(s128a, KEY, 2));
    sa = rnd_st();
    g1 = rnd128();
    tv[5] = mk(sa, g1, 1'b1, fin(sa, g1, 1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", 128'(v1), 128'd0);
    chk("rst_tag", t1, '0);
    chk("rst_ok", 128'(ok1), 128'd0);
    chk("rst_busy", 128'(b1), 128'd0);
    chk("rst_ready", 128'(r1), 128'd1);
    for (int i = 0; i < 6; i++) begin
      run(tv[i].s, tv[i].k, tv[i].d, tv[i].t, g1, o1, g2, o2);
      chk($sformatf("vec%0d_tag", i), g1, tv[i].e1);
      chk($sformatf("vec%0d_ok", i), 128'(o1), 128'(tv[i].o1));
      chk($sformatf("vec%0d_tag_a", i), g2, tv[i].e2);
      chk($sformatf("vec%0d_ok_a", i), 128'(o2), 128'(tv[i].o2));
    end
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      sa = rnd_st();
      hold = rnd128();
      o1 = 1'($urandom_range(1));
      v = mk(sa, hold, o1, $urandom_range(1) ? fin(sa, hold, 1) : rnd128());
      run(v.s, v.k, v.d, v.t, g1, o1, g2, o2);
      chk("rand_tag", g1, v.e1);
      chk("rand_ok", 128'(o1), 128'(v.o1));
      chk("rand_tag_a", g2, v.e2);
      chk("rand_ok_a", 128'(o2), 128'(v.o2));
    end
    @(negedge clk);
    state_i = s128;
    key_i = KEY;
    dec = 1'b0;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      state_i = rnd_st();
      tick();
      chk("bp_valid", 128'(v1), 128'd1);
      chk("bp_ready", 128'(r1), 128'd0);
      chk("bp_tag", t1, KT);
    end
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("bp_rel_valid", 128'(v1), 128'd0);
    chk("bp_rel_ready", 128'(r1), 128'd1);
    chk("bp_rel_tag", t1, KT);
    tick();
    chk("bp_no_capture", 128'(b1), 128'd0);
    @(negedge clk);
    state_i = s128;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 128'(v1), 128'd0);
    chk("mid_rst_busy", 128'(b1), 128'd0);
    chk("mid_rst_ready", 128'(r1), 128'd1);
    o1 = 1'b0;
    repeat (14) begin
      tick();
      o1 = o1 | v1;
    end
    chk("mid_rst_no_pulse", 128'(o1), 128'd0);
    run(s128, KEY, 1'b0, '0, g1, o1, g2, o2);
    chk("mid_rst_kat", g1, KT);
    sa = rnd_st();
    sb = rnd_st();
    @(negedge clk);
    state_i = sa;
    key_i = KEY;
    dec = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    tick();
    state_i = sb;
    wait_valid();
    chk("b2b_tag0", t1, fin(sa, KEY, 1));
    tick();
    chk("b2b_idle", 128'({v1, r1}), 128'b01);
    tick();
    chk("b2b_accept", 128'(b1), 128'd1);
    valid_i = 1'b0;
    wait_valid();
    chk("b2b_tag1", t1, fin(sb, KEY, 1));
    tick();
    ready_i = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
